// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage data access path.
package mem_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic       ld_v;
    logic [2:0] ld_f3;
    logic [1:0] ld_off;
    logic       mis;
  } meta_t;

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic m;
    m = 1'b0;
    case (f3)
      F3_H, F3_HU: m = off[0];
      F3_W:        m = (off != 2'b00);
      default:     m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// MEM-stage request, BRAM port A and write-back result bundle.
interface mem_access_unit_if
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) ();

  logic              mem_read;
  logic              mem_write;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] store_data;
  logic [ADDR_W-3:0] ram_addra;
  logic [3:0]        ram_wea;
  logic [DATA_W-1:0] ram_dina;
  logic [DATA_W-1:0] ram_douta;
  logic [DATA_W-1:0] load_data;
  logic              load_valid;
  logic              misalign_exc;

  modport master (
    output mem_read, mem_write, funct3, addr, store_data, ram_douta,
    input  ram_addra, ram_wea, ram_dina, load_data, load_valid, misalign_exc
  );

  modport slave (
    input  mem_read, mem_write, funct3, addr, store_data, ram_douta,
    output ram_addra, ram_wea, ram_dina, load_data, load_valid, misalign_exc
  );

endinterface

// File: rtl/mem_load_extend.sv
// Byte/half lane select with sign or zero extension of a BRAM read word.
// Purely combinational.
module mem_load_extend
  import mem_pkg::*;
(
  input  logic [DATA_W-1:0] raw,
  input  logic [2:0]        ld_f3,
  input  logic [1:0]        ld_off,
  output logic [DATA_W-1:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = raw[{ld_off, 3'b000} +: 8];
    half_sel = raw[{ld_off[1], 4'b0000} +: 16];
    case (ld_f3)
      F3_B:    ext = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    ext = {{16{half_sel[15]}}, half_sel};
      F3_W:    ext = raw;
      F3_BU:   ext = {24'h0, byte_sel};
      F3_HU:   ext = {16'h0, half_sel};
      default: ext = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit for BRAM port A: store lane steering now, load extract one cycle later.
// en=0 holds meta and buffers the first stalled read word; MEM_MISALIGN_TRAP_EN enables misalign traps.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input logic              clk,
  input logic              rst,
  input logic              en,
  input logic              clear,
  mem_access_unit_if.slave bus
);

  logic [1:0]        off;
  logic              mis_now;
  logic [3:0]        wea_c;
  meta_t             meta_d, meta_q;
  logic              hold_v_d, hold_v_q;
  logic [DATA_W-1:0] hold_dat_d, hold_dat_q;
  logic [DATA_W-1:0] raw;
  logic [DATA_W-1:0] ext;

  assign off = bus.addr[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis_now = misaligned(bus.funct3, off);
`else
  assign mis_now = 1'b0;
`endif

  always_comb begin
    wea_c        = 4'b0000;
    bus.ram_dina = bus.store_data << {off, 3'b000};
    case (bus.funct3)
      F3_B: wea_c = 4'b0001 << off;
      F3_H: begin
        wea_c        = 4'b0011 << {off[1], 1'b0};
        bus.ram_dina = bus.store_data << {off[1], 4'b0000};
      end
      F3_W: begin
        wea_c        = 4'b1111;
        bus.ram_dina = bus.store_data;
      end
      default: wea_c = 4'b0000;
    endcase
  end

  assign bus.ram_addra = bus.addr[ADDR_W-1:2];
  assign bus.ram_wea   = (rst || !en || clear || !bus.mem_write || mis_now) ? 4'b0000 : wea_c;

  always_comb begin
    meta_d = meta_q;
    if (en) begin
      if (clear) begin
        meta_d = '0;
      end else begin
        meta_d.ld_v   = bus.mem_read;
        meta_d.ld_f3  = bus.funct3;
        meta_d.ld_off = off;
        meta_d.mis    = (bus.mem_read | bus.mem_write) & mis_now;
      end
    end
  end

  // Only the first stalled cycle's read word belongs to the load held in meta.
  always_comb begin
    hold_v_d   = hold_v_q;
    hold_dat_d = hold_dat_q;
    if (en) begin
      hold_v_d = 1'b0;
    end else if (!hold_v_q) begin
      hold_v_d   = 1'b1;
      hold_dat_d = bus.ram_douta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q     <= '0;
      hold_v_q   <= 1'b0;
      hold_dat_q <= '0;
    end else begin
      meta_q     <= meta_d;
      hold_v_q   <= hold_v_d;
      hold_dat_q <= hold_dat_d;
    end
  end

  assign raw = hold_v_q ? hold_dat_q : bus.ram_douta;

  mem_load_extend u_extend (
    .raw    (raw),
    .ld_f3  (meta_q.ld_f3),
    .ld_off (meta_q.ld_off),
    .ext    (ext)
  );

  assign bus.load_valid = meta_q.ld_v & ~meta_q.mis;
  assign bus.load_data  = bus.load_valid ? ext : '0;

`ifdef MEM_MISALIGN_TRAP_EN
  assign bus.misalign_exc = meta_q.mis;
`else
  assign bus.misalign_exc = 1'b0;
`endif

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-access stage logic that sits directly upstream of the dual-port data BRAM, port A (the CPU side).
- Store side: turns the MEM-stage request into the word address, 4-bit byte write enable and lane-shifted write data.
- Load side: the BRAM reads synchronously, so the block carries load metadata one cycle and extracts/extends the BRAM output for write-back.
- Load side also buffers BRAM output across pipeline stalls so load data is never lost.

Parameters:
- ADDR_W, 32, byte address width; the RAM word address is ADDR_W-2 bits.
- DATA_W, 32, data width; fixed at 32 (byte lanes assume 4 lanes).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  pipeline advance; 0 = stall, hold state
- clear  in  1  flush of the MEM->WB boundary; takes effect only when en=1
- mem_read  in  1  load request this cycle
- mem_write  in  1  store request this cycle
- funct3  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  byte address
- store_data  in  32  unshifted rs2 value
- ram_addra  out  30  word address, addr[31:2]
- ram_wea  out  4  byte write enable
- ram_dina  out  32  lane-aligned write data
- ram_douta  in  32  BRAM read data, valid one cycle after address
- load_data  out  32  extended load result for WB
- load_valid  out  1  load_data belongs to a retired load
- misalign_exc  out  1  registered misaligned-access flag for the access now in WB

Behaviour:
- Store path (combinational):
  - ram_addra = addr[31:2].
  - ram_wea: SB gives 4'b0001<<addr[1:0]; SH gives 4'b0011<<{addr[1],1'b0}; SW gives 4'b1111.
  - ram_wea is 0 when mem_write=0, en=0, clear=1, rst=1, or the access is misaligned.
  - Unused funct3 values on a store are treated as no write.
  - ram_dina = store_data << (8*addr[1:0]); SH shifts by 16*addr[1]; SW is unshifted.
- Misalignment:
  - H/HU/SH with addr[0]=1 is misaligned.
  - W/SW with addr[1:0]!=0 is misaligned.
  - Byte accesses are never misaligned.
- Meta register fields: ld_v, ld_f3, ld_off[1:0], mis.
  - rst=1, or en=1 with clear=1: all fields cleared to 0.
  - en=1 with clear=0: captures mem_read, funct3, addr[1:0], and (mem_read|mem_write)&misaligned.
  - en=0: holds.
- Stall hold buffer: registers hold_v and hold_d.
  - rst: hold_v=0, hold_d=0.
  - en=0 and hold_v=0: hold_d<=ram_douta, hold_v<=1. This captures the first-stall-cycle data, which belongs to the load in meta.
  - en=0 and hold_v=1: hold.
  - en=1: hold_v<=0.
  - raw = hold_v ? hold_d : ram_douta.
- Extraction (combinational from raw and meta):
  - B/BU selects byte raw[8*off+:8]; H/HU selects half raw[16*off[1]+:16].
  - B and H sign-extend; BU and HU zero-extend; W passes raw through.
- Outputs:
  - load_data = (ld_v & !mis) ? extracted : 0.
  - load_valid = ld_v & !mis.
  - misalign_exc = mis.
- Latency: load address presented in cycle N gives load_data in cycle N+1 (en=1 throughout). A stall of any length keeps load_data stable.
- Reset mid-stall: buffer and meta clear; outputs go to 0 on the next edge.
- Reset values: load_data=0, load_valid=0, misalign_exc=0, ram_wea=0.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- Defined: misalignment detection, store suppression, zeroed load result and misalign_exc behave as above.
- Undefined: misalign_exc is tied to 0 and mis is always 0. Accesses are forced aligned: the lane offset is masked (H uses addr[1] only, W uses offset 0) and stores always write.

Decomposition:
- Package mem_pkg:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - DATA_W.
  - A meta-record typedef {ld_v, ld_f3, ld_off, mis}.
- One sub-module, mem_load_extend: combinational byte/half select plus sign/zero extend, driven by raw, ld_f3 and ld_off.

Test Plan:
- SB, addr=0x103, store_data=0x000000AB, en=1 -> ram_wea=4'b1000, ram_dina=0xAB000000, ram_addra=0x40.
- RAM word 0x8000F0FF at addr 0x200; LB at 0x200, then LBU at 0x201 -> load_data=0xFFFFFFFF, then 0x000000F0, one cycle after each address.
- LH at 0x202 returns 0x00008000 raw half; en=0 for 3 cycles while ram_douta changes to 0x12345678 -> load_data holds 0xFFFF8000 all 3 cycles and load_valid=1.
- With the macro defined: SW at 0x006 -> ram_wea=0; next cycle misalign_exc=1, load_valid=0, load_data=0.
- LW at 0x10 with en=1, clear=1 -> next cycle load_valid=0, load_data=0; the next LW without clear returns the RAM word.
- rst=1 asserted during a stall with hold_v=1 -> next edge: load_data=0, load_valid=0, misalign_exc=0, ram_wea=0 while rst is high.
